button_repeat_pulser: RTL and testbench



---
 rtl/button_repeat_pulser.sv | 133 +++++++++++++
 tb/tb_button_repeat_pulser.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/button_repeat_pulser.sv
// Push-button front end: 2-FF synchronizer, debounce FSM and auto-repeat timer
// producing single-cycle enable pulses plus a debounced level.
module button_repeat_pulser #(
    parameter int unsigned DB_CYCLES     = 500000,
    parameter int unsigned HOLD_CYCLES   = 50000000,
    parameter int unsigned REPEAT_CYCLES = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    input  logic repeat_en,
    output logic en_pulse,
    output logic pressed
);

    // One counter serves all three timing phases, so it is sized for the longest.
    localparam int unsigned MAX_DB_HOLD = (DB_CYCLES > HOLD_CYCLES) ? DB_CYCLES : HOLD_CYCLES;
    localparam int unsigned MAX_CYCLES  = (MAX_DB_HOLD > REPEAT_CYCLES) ? MAX_DB_HOLD : REPEAT_CYCLES;
    localparam int          CNT_W       = $clog2(MAX_CYCLES);

    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DB_PRESS,
        S_HOLD,
        S_REPEAT,
        S_DB_RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             sync1_q, btn_sync_q;
    logic             en_pulse_q, en_pulse_d;
    logic             pressed_q, pressed_d;

    assign cnt_inc = cnt_q + 1'b1;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            btn_sync_q <= 1'b0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            en_pulse_q <= 1'b0;
            pressed_q  <= 1'b0;
        end else begin
            sync1_q    <= btn_in;
            btn_sync_q <= sync1_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            en_pulse_q <= en_pulse_d;
            pressed_q  <= pressed_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_inc;
        en_pulse_d = 1'b0;
        pressed_d  = pressed_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (btn_sync_q) begin
                    state_d = S_DB_PRESS;
                end
            end

            S_DB_PRESS: begin
                if (!btn_sync_q) begin
                    state_d = S_IDLE;
                end else if (cnt_q == DB_LAST) begin
                    state_d    = S_HOLD;
                    en_pulse_d = 1'b1;
                    pressed_d  = 1'b1;
                end
            end

            S_HOLD: begin
                if (!btn_sync_q) begin
                    state_d = S_DB_RELEASE;
                end else if (!repeat_en) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d    = S_REPEAT;
                    en_pulse_d = 1'b1;
                end
            end

            S_REPEAT: begin
                if (!btn_sync_q) begin
                    state_d = S_DB_RELEASE;
                end else if (!repeat_en) begin
                    state_d = S_HOLD;
                end else if (cnt_q == REPEAT_LAST) begin
                    cnt_d      = '0;
                    en_pulse_d = 1'b1;
                end
            end

            S_DB_RELEASE: begin
                if (btn_sync_q) begin
                    state_d = S_HOLD;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = S_IDLE;
                    pressed_d = 1'b0;
                end
            end

            default: begin
                state_d   = S_IDLE;
                pressed_d = 1'b0;
            end
        endcase

        // Each phase times from zero, so any transition restarts the counter.
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    assign en_pulse = en_pulse_q;
    assign pressed  = pressed_q;

endmodule

// File: tb/tb_button_repeat_pulser.sv
// Directed bench for button_repeat_pulser: expected pulse edges are queued when
// a scenario starts and matched by a monitor as pulses appear.
module tb_button_repeat_pulser;

    localparam int DB   = 4;
    localparam int HOLD = 10;
    localparam int RPT  = 3;

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic btn_in    = 1'b0;
    logic repeat_en = 1'b0;
    logic en_pulse;
    logic pressed;

    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   sb_q[$];
    logic prev_pulse = 1'b0;

    button_repeat_pulser #(
        .DB_CYCLES    (DB),
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(RPT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_in   (btn_in),
        .repeat_en(repeat_en),
        .en_pulse (en_pulse),
        .pressed  (pressed)
    );

    always #5 clk = ~clk;

    // cyc equals the number of rising edges seen; read on falling edges.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Drop the button now (on a falling edge, cyc = r): R0 = edge r+1,
    // so pressed must still be 1 after edge r+6 and 0 after edge r+7.
    task automatic release_check(input string tag);
        int r;
        r = cyc;
        btn_in = 1'b0;
        wait_cyc(r + DB + 2);
        check({tag, "_pressed_before_fall"}, pressed, 1);
        wait_cyc(r + DB + 3);
        check({tag, "_pressed_fall"}, pressed, 0);
    endtask

    // Every pulse must match the head of the scoreboard and be one cycle wide.
    always @(negedge clk) begin
        if (en_pulse === 1'b1) begin
            check("pulse_expected", (sb_q.size() > 0), 1);
            if (sb_q.size() > 0) check("pulse_cycle", cyc, sb_q.pop_front());
        end
        if (prev_pulse === 1'b1) check("pulse_width", en_pulse, 0);
        prev_pulse <= en_pulse;
    end

    initial begin
        int n;
        int m;
        logic [5:0] bounce;
        int rep_offs[8];

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_en_pulse", en_pulse, 0);
        check("reset_pressed", pressed, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_pressed", pressed, 0);

        // S1: clean press without repeat; single pulse after E6
        repeat_en = 1'b0;
        n = cyc;
        btn_in = 1'b1;
        sb_q.push_back(n + 1 + DB + 2);
        wait_cyc(n + DB + 2);
        check("s1_pressed_before", pressed, 0);
        wait_cyc(n + DB + 3);
        check("s1_pressed_rise", pressed, 1);
        wait_cyc(n + 40);
        release_check("s1");
        wait_cyc(cyc + 10);
        check("s1_pending", sb_q.size(), 0);

        // S2: bounce 1,0,1,1,0,1 then low: no pulse, pressed stays 0
        bounce = 6'b101101;
        for (int i = 0; i < 6; i++) begin
            btn_in = bounce[i];
            @(negedge clk);
            check("s2_pressed_bounce", pressed, 0);
        end
        btn_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("s2_pressed_settle", pressed, 0);
        end
        check("s2_pending", sb_q.size(), 0);

        // S3: auto-repeat; pulses after E6, E16, then every 3 edges to E34.
        // Release lands so btn_sync falls exactly on the E37 timeout edge.
        rep_offs = '{6, 16, 19, 22, 25, 28, 31, 34};
        repeat_en = 1'b1;
        n = cyc;
        btn_in = 1'b1;
        for (int i = 0; i < 8; i++) sb_q.push_back(n + 1 + rep_offs[i]);
        wait_cyc(n + 1 + 20);
        check("s3_pressed_held", pressed, 1);
        wait_cyc(n + 1 + 34);
        release_check("s3");
        wait_cyc(cyc + 8);
        check("s3_pending", sb_q.size(), 0);

        // S4: one low cycle at E10; HOLD re-entered at E13, next pulse at E23
        n = cyc;
        btn_in = 1'b1;
        sb_q.push_back(n + 1 + 6);
        sb_q.push_back(n + 1 + 23);
        sb_q.push_back(n + 1 + 26);
        sb_q.push_back(n + 1 + 29);
        wait_cyc(n + 1 + 9);
        btn_in = 1'b0;
        wait_cyc(n + 1 + 10);
        btn_in = 1'b1;
        for (int k = 11; k <= 16; k++) begin
            wait_cyc(n + 1 + k);
            check("s4_pressed_glitch", pressed, 1);
        end
        wait_cyc(n + 1 + 29);
        release_check("s4");
        wait_cyc(cyc + 8);
        check("s4_pending", sb_q.size(), 0);

        // S5: repeat_en dropped after the E19 pulse, raised after E30
        n = cyc;
        btn_in = 1'b1;
        sb_q.push_back(n + 1 + 6);
        sb_q.push_back(n + 1 + 16);
        sb_q.push_back(n + 1 + 19);
        sb_q.push_back(n + 1 + 40);
        sb_q.push_back(n + 1 + 43);
        wait_cyc(n + 1 + 19);
        repeat_en = 1'b0;
        wait_cyc(n + 1 + 25);
        check("s5_pressed_paused", pressed, 1);
        wait_cyc(n + 1 + 30);
        check("s5_pressed_resume", pressed, 1);
        repeat_en = 1'b1;
        wait_cyc(n + 1 + 43);
        release_check("s5");
        wait_cyc(cyc + 8);
        check("s5_pending", sb_q.size(), 0);

        // S6: reset while en_pulse is high, button kept pressed
        repeat_en = 1'b0;
        n = cyc;
        btn_in = 1'b1;
        sb_q.push_back(n + 1 + DB + 2);
        wait_cyc(n + 1 + DB + 2);
        #1 reset = 1'b1;
        #1;
        check("s6_reset_en_pulse", en_pulse, 0);
        check("s6_reset_pressed", pressed, 0);
        @(negedge clk);
        check("s6_reset_held_pressed", pressed, 0);
        reset = 1'b0;
        m = cyc;
        sb_q.push_back(m + 1 + DB + 2);
        wait_cyc(m + DB + 2);
        check("s6_pressed_before", pressed, 0);
        wait_cyc(m + DB + 3);
        check("s6_pressed_rise", pressed, 1);
        wait_cyc(m + 20);
        release_check("s6");
        wait_cyc(cyc + 8);
        check("s6_pending", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
